password_bank: RTL

Parametrised multi-slot password store with a built-in serial verifier, used by the serial password lock.
- Holds SLOTS passwords of DIGITS digits, each digit WIDTH bits.
- Supports per-digit write and registered read-back.
- Compares a digit stream, one digit per valid cycle, against a selected slot and reports match/mismatch.
- Counts consecutive failures and locks out after MAX_FAIL; the lock FSM sits between keypad decoding and the unlock actuator.

---
 rtl/password_pkg.sv | 18 +
 rtl/password_mem.sv | 42 ++++
 rtl/password_bank.sv | 127 ++++++++++++
 3 files changed

// File: rtl/password_pkg.sv
// Shared types and width helpers for the password bank and its storage array.
package password_pkg;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    RESULT
  } state_t;

  function automatic int addr_w(input int digits);
    return ($clog2(digits) > 1) ? $clog2(digits) : 1;
  endfunction

  function automatic int slot_w(input int slots);
    return ($clog2(slots) > 1) ? $clog2(slots) : 1;
  endfunction

endpackage

// File: rtl/password_mem.sv
// Slot x digit register array: gated write, registered read-back, and a
// combinational read port feeding the serial comparator.
module password_mem
  import password_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int DIGITS = 4,
  parameter int SLOTS  = 2,
  localparam int ADDR_W = addr_w(DIGITS),
  localparam int SLOT_W = slot_w(SLOTS)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              we,
  input  logic [SLOT_W-1:0] wr_slot,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic [SLOT_W-1:0] rd_slot,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data,
  input  logic [SLOT_W-1:0] cmp_slot,
  input  logic [ADDR_W-1:0] cmp_idx,
  output logic [WIDTH-1:0]  cmp_digit
);

  logic [WIDTH-1:0] mem [SLOTS][DIGITS];
  logic             rd_ok;

  assign rd_ok     = (int'(rd_slot) < SLOTS) && (int'(rd_addr) < DIGITS);
  assign cmp_digit = mem[cmp_slot][cmp_idx];

  always_ff @(posedge CLK) begin
    if (RST) begin
      mem     <= '{default: '0};
      rd_data <= '0;
    end else begin
      if (we) mem[wr_slot][wr_addr] <= wr_data;
      rd_data <= rd_ok ? mem[rd_slot][rd_addr] : '0;
    end
  end

endmodule

// File: rtl/password_bank.sv
// Multi-slot password store with serial verifier, failure counter and lockout.
module password_bank
  import password_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int DIGITS   = 4,
  parameter int SLOTS    = 2,
  parameter int MAX_FAIL = 3,
  localparam int ADDR_W = addr_w(DIGITS),
  localparam int SLOT_W = slot_w(SLOTS),
  localparam int FC_W   = $clog2(MAX_FAIL + 1)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [SLOT_W-1:0] slot_sel,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data,
  input  logic              cmp_start,
  input  logic              digit_valid,
  input  logic [WIDTH-1:0]  digit,
  input  logic              cmp_abort,
  input  logic              unlock,
  output logic              busy,
  output logic              done,
  output logic              match,
  output logic              wr_err,
  output logic              locked,
  output logic [FC_W-1:0]   fail_cnt
);

  state_t            state, state_nxt;
  logic [SLOT_W-1:0] slot_q;
  logic [ADDR_W-1:0] idx_q;
  logic              mism_q;
  logic [WIDTH-1:0]  cmp_digit;
  logic              slot_ok, addr_ok, wr_ok, start_ok;
  logic              take_digit, digit_ne, last_digit;

  assign slot_ok    = int'(slot_sel) < SLOTS;
  assign addr_ok    = int'(wr_addr) < DIGITS;
  assign wr_ok      = wr_en && (state == IDLE) && slot_ok && addr_ok;
  assign start_ok   = cmp_start && (state == IDLE) && !locked && slot_ok;
  assign take_digit = (state == COLLECT) && !cmp_abort && digit_valid;
  assign digit_ne   = digit != cmp_digit;
  assign last_digit = idx_q == ADDR_W'(DIGITS - 1);
  assign busy       = state == COLLECT;
  assign done       = state == RESULT;

  password_mem #(
    .WIDTH (WIDTH),
    .DIGITS(DIGITS),
    .SLOTS (SLOTS)
  ) u_mem (
    .CLK      (CLK),
    .RST      (RST),
    .we       (wr_ok),
    .wr_slot  (slot_sel),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rd_slot  (slot_sel),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .cmp_slot (slot_q),
    .cmp_idx  (idx_q),
    .cmp_digit(cmp_digit)
  );

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_ok) state_nxt = COLLECT;
      COLLECT: begin
        if (cmp_abort)                     state_nxt = IDLE;
        else if (digit_valid && last_digit) state_nxt = RESULT;
      end
      RESULT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // match is registered on the last digit so it is already valid while done is high
  always_ff @(posedge CLK) begin
    if (RST) begin
      slot_q   <= '0;
      idx_q    <= '0;
      mism_q   <= 1'b0;
      match    <= 1'b0;
      wr_err   <= 1'b0;
      locked   <= 1'b0;
      fail_cnt <= '0;
    end else begin
      wr_err <= wr_en && !wr_ok;
      if (start_ok) begin
        slot_q <= slot_sel;
        idx_q  <= '0;
        mism_q <= 1'b0;
        match  <= 1'b0;
      end
      if ((state == IDLE) && unlock) begin
        locked   <= 1'b0;
        fail_cnt <= '0;
      end
      if (take_digit) begin
        mism_q <= mism_q | digit_ne;
        idx_q  <= idx_q + ADDR_W'(1);
        if (last_digit) match <= !(mism_q | digit_ne);
      end
      if (state == RESULT) begin
        if (!mism_q) begin
          fail_cnt <= '0;
        end else if (fail_cnt != FC_W'(MAX_FAIL)) begin
          fail_cnt <= fail_cnt + FC_W'(1);
          if (fail_cnt == FC_W'(MAX_FAIL - 1)) locked <= 1'b1;
        end
      end
    end
  end

endmodule
